aes_key_expander_seq: RTL and testbench
=======================================

Name: aes_key_expander_seq

Overview:
- Iterative, parametrised AES key expansion. Supports AES-128/192/256, selected at elaboration.
- Generates one 32-bit schedule word per clock into an internal round-key store. The cipher rounds read that store by round index.
- Replaces the combinational 128-bit-only expansion, which presented a flat 1408-bit schedule bus. Cuts area: one S-box word path instead of ten.

Parameters:
- KEY_BITS, 128, key length; legal values 128/192/256; any other value is an elaboration error.
- NK, KEY_BITS/32, key words (derived localparam).
- NR, NK+6, number of rounds (derived localparam).
- NW, 4*(NR+1), total schedule words: 44/52/60 (derived localparam).

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to expand key
- key  in  [0:KEY_BITS-1]  cipher key; bit 0 = MSB of byte 0; sampled only on accepted start
- busy  out  1  expansion in progress
- done  out  1  schedule complete and valid; held until next accepted start
- rk_idx  in  4  round-key index 0..NR
- rk_data  out  [0:127]  round key for rk_idx; registered
- rk_valid  out  1  rk_data valid
- zeroize  in  1  present only with AES_KEYEXP_ZEROIZE_EN

Behaviour:
- Reset (async, n_rst=0) values:
  - outputs: busy=0, done=0, rk_data=0, rk_valid=0
  - internals: state=IDLE, word counter=0, rcon=8'h01, store contents=0
- FSM states: IDLE, LOAD, EXPAND, DONE.
- Start acceptance: start is accepted in IDLE or DONE. It is ignored in LOAD/EXPAND; no queuing, no restart.
- On accepted start:
  - key is latched; done clears the same edge.
  - Next state is LOAD.
- LOAD (1 cycle):
  - writes w[0..NK-1] from key.
  - sets i=NK, k=0 (k = i mod NK, a separate counter; no divider), rcon=01.
- EXPAND, one word per cycle:
  - temp=w[i-1].
  - If k==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon<=xtime(rcon), reducing by 0x1B on overflow.
  - If NK==8 and k==4: temp=SubWord(temp).
  - w[i]=w[i-NK]^temp.
  - k wraps at NK-1→0. At i==NW-1, go to DONE.
- busy=1 in LOAD and EXPAND.
- Latency, accepted start to done=1: 1+1+(NW-NK) cycles. That is 42 (128), 48 (192), 54 (256).
- DONE: done=1; returns to LOAD on a new start.
- Read port (1-cycle latency):
  - rk_data<=words 4*rk_idx..4*rk_idx+3; rk_valid<=done && rk_idx<=NR.
  - If rk_idx>NR or not done: rk_data<=0, rk_valid<=0.
- Read during EXPAND returns 0/invalid; stale schedule is never exposed.
- Reset mid-EXPAND: immediate return to IDLE; store cleared; done=0.
- rcon never exceeds its 10 used values; for NK=4 the last value used is 0x36.

Optional Feature:
- Macro: AES_KEYEXP_ZEROIZE_EN.
- With macro:
  - zeroize port exists.
  - zeroize=1 in any state moves to a WIPE state that clears one word per cycle (NW cycles). busy=1 and done=0 during WIPE; start is ignored.
  - WIPE then goes to IDLE.
  - zeroize has priority over a simultaneous start.
- Without macro: no port, no WIPE state; only reset clears the store.

Decomposition:
- Package aes_pkg:
  - typedef word_t (logic [0:31]), typedef block_t (logic [0:127])
  - 256-entry SBOX constant array
  - functions sub_word, rot_word, xtime
  - typedef enum state_t {IDLE, LOAD, EXPAND, DONE, WIPE}
- Sub-module aes_sub_word: 4 parallel S-box lookups, combinational, shared with the cipher round datapath.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - done rises 42 cycles later.
  - rk_idx=1 → a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 000102…1617: done after 48 cycles; rk_idx=12 → a4970a331a78dc09c418c271e3a41d5d.
- KEY_BITS=256, key 000102…1e1f: done after 54 cycles; rk_idx=14 → 24fc79ccbf0979e9371ac23c6d68de36; rk_idx=15 → rk_valid=0, rk_data=0.
- Start re-pulsed mid-EXPAND with a different key: ignored; result matches the first key. Start in DONE with key 000102…0f: done drops next cycle and returns 42 cycles later with the new schedule.
- n_rst asserted at EXPAND cycle 20: busy/done/rk_valid=0 immediately. A following start completes correctly.
- With AES_KEYEXP_ZEROIZE_EN: zeroize in DONE → busy for NW cycles, then all rk_idx read 0 with rk_valid=0. zeroize+start in the same cycle → WIPE wins.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, S-box table and small word helpers used by the key expander
// and the cipher round datapath.
package aes_pkg;

    typedef logic [0:31]  word_t;
    typedef logic [0:127] block_t;

    typedef enum logic [2:0] {IDLE, LOAD, EXPAND, DONE, WIPE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte 0 sits in bits [0:7]; every helper keeps that big-endian view.
    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[0:7]], SBOX[w[8:15]], SBOX[w[16:23]], SBOX[w[24:31]]};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[8:31], w[0:7]};
    endfunction

    // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on one 32-bit word; purely combinational so the
// same instance can serve key expansion or a cipher round column.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [0:31] word_i,
    output logic [0:31] word_o
);

    // One table lookup per byte lane.
    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_expander_seq.sv
// Iterative AES key expansion: one schedule word per clock into a round-key
// store, read back one 128-bit round key at a time with one cycle of latency.
// Optional macro AES_KEYEXP_ZEROIZE_EN adds a zeroize input and a WIPE state
// that clears the store word by word.
module aes_key_expander_seq
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                n_rst,
`ifdef AES_KEYEXP_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                start,
    input  logic [0:KEY_BITS-1] key,
    output logic                busy,
    output logic                done,
    input  logic [3:0]          rk_idx,
    output logic [0:127]        rk_data,
    output logic                rk_valid
);

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned IW = $clog2(NW);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gen_bad_key_bits
        $error("aes_key_expander_seq: KEY_BITS must be 128, 192 or 256");
    end

    state_t              state_q, state_d;
    logic [0:KEY_BITS-1] key_q, key_d;
    word_t               w_q [NW];
    word_t               w_d [NW];
    logic [IW-1:0]       i_q, i_d;
    logic [2:0]          k_q, k_d;
    logic [7:0]          rcon_q, rcon_d;
    block_t              rk_data_q, rk_data_d;
    logic                rk_valid_q, rk_valid_d;

    logic  wipe_req;
    logic  last_word;
    word_t prev_w, back_w, sub_in, sub_out, temp;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign wipe_req = zeroize;
`else
    assign wipe_req = 1'b0;
`endif

    assign last_word = (i_q == IW'(NW - 1));

    // w[i-1] and w[i-NK] are only meaningful in EXPAND, where i >= NK.
    assign prev_w = w_q[i_q - IW'(1)];
    assign back_w = w_q[i_q - IW'(NK)];
    assign sub_in = (k_q == 3'd0) ? rot_word(prev_w) : prev_w;

    aes_sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    // Transform applied to w[i-1] before folding in w[i-NK].
    always_comb begin
        temp = prev_w;
        if (k_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if ((NK == 8) && (k_q == 3'd4)) begin
            temp = sub_out;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a wipe request beats everything; start is only heard in IDLE/DONE.
    always_comb begin
        state_d = state_q;
        if (wipe_req) begin
            state_d = WIPE;
        end else begin
            unique case (state_q)
                IDLE, DONE: if (start) state_d = LOAD;
                LOAD:       state_d = EXPAND;
                EXPAND:     if (last_word) state_d = DONE;
`ifdef AES_KEYEXP_ZEROIZE_EN
                WIPE:       if (last_word) state_d = IDLE;
`endif
                default:    state_d = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == LOAD) || (state_q == EXPAND) || (state_q == WIPE);
        done = (state_q == DONE);
    end

    // Datapath registers: latched key, schedule store, word and rcon counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_q  <= '0;
            w_q    <= '{default: '0};
            i_q    <= '0;
            k_q    <= '0;
            rcon_q <= 8'h01;
        end else begin
            key_q  <= key_d;
            w_q    <= w_d;
            i_q    <= i_d;
            k_q    <= k_d;
            rcon_q <= rcon_d;
        end
    end

    // Datapath next state: load key words, then generate one word per cycle.
    always_comb begin
        key_d  = key_q;
        w_d    = w_q;
        i_d    = i_q;
        k_d    = k_q;
        rcon_d = rcon_q;
        if (wipe_req) begin
            key_d  = '0;
            i_d    = '0;
            k_d    = '0;
            rcon_d = 8'h01;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) key_d = key;
                end
                LOAD: begin
                    for (int j = 0; j < NK; j++) begin
                        w_d[j] = key_q[32*j +: 32];
                    end
                    i_d    = IW'(NK);
                    k_d    = '0;
                    rcon_d = 8'h01;
                end
                EXPAND: begin
                    w_d[i_q] = back_w ^ temp;
                    i_d      = i_q + IW'(1);
                    k_d      = (k_q == 3'(NK - 1)) ? 3'd0 : k_q + 3'd1;
                    // Stop advancing once the final rcon has been consumed.
                    if ((k_q == 3'd0) && (32'(i_q) < NW - NK)) begin
                        rcon_d = xtime(rcon_q);
                    end
                end
`ifdef AES_KEYEXP_ZEROIZE_EN
                WIPE: begin
                    w_d[i_q] = '0;
                    i_d      = i_q + IW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    // Read port: only a finished schedule is ever exposed.
    always_comb begin
        rk_data_d  = '0;
        rk_valid_d = 1'b0;
        if ((state_q == DONE) && (32'(rk_idx) <= NR)) begin
            rk_valid_d = 1'b1;
            for (int b = 0; b < 4; b++) begin
                rk_data_d[32*b +: 32] = w_q[IW'({rk_idx, 2'(b)})];
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rk_data_q  <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            rk_data_q  <= rk_data_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    assign rk_data  = rk_data_q;
    assign rk_valid = rk_valid_q;

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Bench for aes_key_expander_seq: one instance per key size, checked against a
// reference schedule built from GF(2^8) arithmetic.
module tb_aes_key_expander_seq;

    logic clk = 1'b0;
    logic n_rst;

    logic         start_a   [3];
    logic [0:255] key_a     [3];
    logic [3:0]   rk_idx_a  [3];
    logic [0:127] rk_data_a [3];
    logic [2:0]   busy_v, done_v, valid_v;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic         zeroize_a [3];
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  sbox_t [256];
    logic [31:0] ref_w  [3][60];

    always #5 clk = ~clk;

    aes_key_expander_seq #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .n_rst(n_rst),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(zeroize_a[0]),
`endif
        .start(start_a[0]), .key(key_a[0][0:127]), .busy(busy_v[0]), .done(done_v[0]),
        .rk_idx(rk_idx_a[0]), .rk_data(rk_data_a[0]), .rk_valid(valid_v[0])
    );

    aes_key_expander_seq #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .n_rst(n_rst),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(zeroize_a[1]),
`endif
        .start(start_a[1]), .key(key_a[1][0:191]), .busy(busy_v[1]), .done(done_v[1]),
        .rk_idx(rk_idx_a[1]), .rk_data(rk_data_a[1]), .rk_valid(valid_v[1])
    );

    aes_key_expander_seq #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .n_rst(n_rst),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(zeroize_a[2]),
`endif
        .start(start_a[2]), .key(key_a[2]), .busy(busy_v[2]), .done(done_v[2]),
        .rk_idx(rk_idx_a[2]), .rk_data(rk_data_a[2]), .rk_valid(valid_v[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p = '0;
        for (int n = 0; n < 8; n++) if (b[n]) p ^= 15'(a) << n;
        for (int n = 14; n >= 8; n--) if (p[n]) p ^= 15'(9'h11b) << (n - 8);
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic int nk_of(input int m);
        return 4 + 2 * m;
    endfunction

    task automatic build_schedule(input int m, input logic [0:255] k);
        int nk = nk_of(m);
        int nw = 4 * (nk + 7);
        logic [7:0] rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) ref_w[m][i] = k[32*i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = ref_w[m][i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            ref_w[m][i] = ref_w[m][i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int m, input int r);
        return {ref_w[m][4*r], ref_w[m][4*r+1], ref_w[m][4*r+2], ref_w[m][4*r+3]};
    endfunction

    function automatic logic [0:255] rand_key();
        logic [0:255] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then count edges until done; latency counts the accepting edge.
    task automatic start_and_wait(input int m, input logic [0:255] k, input string tag);
        int cyc;
        build_schedule(m, k);
        key_a[m]   = k;
        start_a[m] = 1'b1;
        step();
        start_a[m] = 1'b0;
        cyc = 1;
        check({tag, "_done_drop"}, 128'(done_v[m]), 128'(0));
        check({tag, "_busy"}, 128'(busy_v[m]), 128'(1));
        while (!done_v[m] && cyc < 200) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(42 + 6 * m));
    endtask

    task automatic read_all(input int m, input logic exp_done, input string tag);
        logic v;
        for (int r = 0; r < 16; r++) begin
            rk_idx_a[m] = 4'(r);
            step();
            v = exp_done && (r <= nk_of(m) + 6);
            check($sformatf("%s_valid%0d", tag, r), 128'(valid_v[m]), 128'(v));
            if (v) check($sformatf("%s_rk%0d", tag, r), rk_data_a[m], exp_rk(m, r));
            else   check($sformatf("%s_rk%0d", tag, r), rk_data_a[m], 128'(0));
        end
    endtask

    task automatic read_const(input int m, input int r, input logic [127:0] exp,
                              input string tag);
        rk_idx_a[m] = 4'(r);
        step();
        check({tag, "_valid"}, 128'(valid_v[m]), 128'(1));
        check({tag, "_data"}, rk_data_a[m], exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [0:255] ka, kb;
        int cyc;

        n_rst = 1'b0;
        for (int m = 0; m < 3; m++) begin
            start_a[m]  = 1'b0;
            key_a[m]    = '0;
            rk_idx_a[m] = '0;
`ifdef AES_KEYEXP_ZEROIZE_EN
            zeroize_a[m] = 1'b0;
`endif
        end
        build_sbox();
        step();
        step();
        for (int m = 0; m < 3; m++) begin
            check($sformatf("reset_busy%0d", m), 128'(busy_v[m]), 128'(0));
            check($sformatf("reset_done%0d", m), 128'(done_v[m]), 128'(0));
            check($sformatf("reset_valid%0d", m), 128'(valid_v[m]), 128'(0));
            check($sformatf("reset_data%0d", m), rk_data_a[m], 128'(0));
        end
        n_rst = 1'b1;
        step();

        // Known-answer schedules.
        start_and_wait(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, "kat128");
        read_const(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "kat128_rk1");
        read_const(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "kat128_rk10");
        read_all(0, 1'b1, "kat128");

        start_and_wait(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                       "kat192");
        read_const(1, 12, 128'ha4970a331a78dc09c418c271e3a41d5d, "kat192_rk12");
        read_all(1, 1'b1, "kat192");

        start_and_wait(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                       "kat256");
        read_const(2, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "kat256_rk14");
        rk_idx_a[2] = 4'd15;
        step();
        check("kat256_rk15_valid", 128'(valid_v[2]), 128'(0));
        check("kat256_rk15_data", rk_data_a[2], 128'(0));
        read_all(2, 1'b1, "kat256");

        // Random keys, restarting from DONE each time.
        for (int n = 0; n < 2; n++) begin
            for (int m = 0; m < 3; m++) begin
                start_and_wait(m, rand_key(), $sformatf("rand%0d_%0d", n, m));
                read_all(m, 1'b1, $sformatf("rand%0d_%0d", n, m));
            end
        end

        // Start re-pulsed mid-EXPAND must be ignored.
        ka = rand_key();
        kb = ~ka;
        build_schedule(0, ka);
        key_a[0]    = ka;
        start_a[0]  = 1'b1;
        rk_idx_a[0] = 4'd0;
        step();
        start_a[0] = 1'b0;
        cyc = 1;
        repeat (9) begin
            step();
            cyc++;
        end
        check("expand_read_valid", 128'(valid_v[0]), 128'(0));
        check("expand_read_data", rk_data_a[0], 128'(0));
        key_a[0]   = kb;
        start_a[0] = 1'b1;
        step();
        cyc++;
        start_a[0] = 1'b0;
        check("restart_busy", 128'(busy_v[0]), 128'(1));
        while (!done_v[0] && cyc < 200) begin
            step();
            cyc++;
        end
        check("restart_latency", 128'(cyc), 128'(42));
        read_all(0, 1'b1, "restart");

        // Start from DONE with a fresh key.
        start_and_wait(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, "redo128");
        read_all(0, 1'b1, "redo128");

        // Asynchronous reset in the middle of EXPAND.
        key_a[0]   = rand_key();
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        repeat (21) step();
        check("pre_reset_busy", 128'(busy_v[0]), 128'(1));
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_busy", 128'(busy_v[0]), 128'(0));
        check("midrst_done", 128'(done_v[0]), 128'(0));
        check("midrst_valid", 128'(valid_v[0]), 128'(0));
        step();
        n_rst = 1'b1;
        step();
        start_and_wait(0, rand_key(), "after_rst");
        read_all(0, 1'b1, "after_rst");

`ifdef AES_KEYEXP_ZEROIZE_EN
        // Zeroize from DONE: NW busy cycles, then nothing readable.
        zeroize_a[0] = 1'b1;
        step();
        zeroize_a[0] = 1'b0;
        cyc = 0;
        while (busy_v[0] && cyc < 200) begin
            check("wipe_done_low", 128'(done_v[0]), 128'(0));
            cyc++;
            step();
        end
        check("wipe_cycles", 128'(cyc), 128'(44));
        read_all(0, 1'b0, "wiped");

        // Zeroize and start together: the wipe wins.
        start_and_wait(0, rand_key(), "pre_wipe2");
        key_a[0]     = rand_key();
        start_a[0]   = 1'b1;
        zeroize_a[0] = 1'b1;
        step();
        start_a[0]   = 1'b0;
        zeroize_a[0] = 1'b0;
        cyc = 0;
        while (busy_v[0] && cyc < 200) begin
            cyc++;
            step();
        end
        check("wipe_vs_start_cycles", 128'(cyc), 128'(44));
        repeat (3) step();
        check("wipe_vs_start_done", 128'(done_v[0]), 128'(0));
        start_and_wait(0, rand_key(), "after_wipe");
        read_all(0, 1'b1, "after_wipe");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
